// File: rtl/csa_tree_pipe.sv
// Pipelined carry-save compressor tree.
// Reduces NUM_IN operands of WIDTH bits to a redundant (carry, sum) pair
// modulo 2^WIDTH, one register bank per 3:2 level, valid/ready flow control
// driven by a single global advance signal.
// Optional macro CSA_FINAL_ADD_EN appends a carry-propagate stage that
// produces the resolved sum on out_sum.
module csa_tree_pipe #(
   parameter int WIDTH  = 19,
   parameter int NUM_IN = 6
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [NUM_IN-1:0][WIDTH-1:0]  in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WIDTH-1:0]              out_c,
   output logic [WIDTH-1:0]              out_s
`ifdef CSA_FINAL_ADD_EN
   ,
   output logic [WIDTH-1:0]              out_sum
`endif
);

   function automatic int lvl_count(input int n);
      int c;
      c = 0;
      while (n > 2) begin
         n = n - n / 3;
         c++;
      end
      return c;
   endfunction

   // operand count entering level lvl
   function automatic int opnd_count(input int lvl);
      int n;
      n = NUM_IN;
      for (int i = 0; i < lvl; i++) n = n - n / 3;
      return n;
   endfunction

   localparam int LEVELS = (lvl_count(NUM_IN) < 1) ? 1 : lvl_count(NUM_IN);

   if (NUM_IN < 3 || NUM_IN > 32) begin : g_bad_num_in
      $error("csa_tree_pipe: NUM_IN must be in 3..32");
   end

   typedef logic [NUM_IN-1:0][WIDTH-1:0] vec_t;

   // One 3:2 level: triples become (sum, carry) pairs in index order,
   // leftovers follow unchanged. Unused upper slots are zero.
   function automatic vec_t compress(input vec_t v, input int n);
      vec_t r;
      int   nt;
      r  = '0;
      nt = n / 3;
      for (int t = 0; t < NUM_IN / 3; t++) begin
         if (t < nt) begin
            r[2*t]   = v[3*t] ^ v[3*t+1] ^ v[3*t+2];
            r[2*t+1] = ((v[3*t] & v[3*t+1]) | (v[3*t] & v[3*t+2]) |
                        (v[3*t+1] & v[3*t+2])) << 1;
         end
      end
      for (int k = 0; k < 2; k++) begin
         if (k < n - 3*nt) r[2*nt+k] = v[3*nt+k];
      end
      return r;
   endfunction

   logic       adv;
   vec_t       dat_d [LEVELS];
   vec_t       dat_q [LEVELS];
   logic [LEVELS-1:0] vld_d, vld_q;
   logic             tree_valid;
   logic [WIDTH-1:0] tree_c, tree_s;

   assign adv      = !out_valid | out_ready;
   assign in_ready = adv;

   // Tree levels: load from predecessor on advance, hold otherwise.
   always_comb begin
      vld_d    = vld_q;
      dat_d[0] = dat_q[0];
      if (adv) begin
         vld_d[0] = in_valid;
         if (in_valid) dat_d[0] = compress(in_data, NUM_IN);
      end
      for (int l = 1; l < LEVELS; l++) begin
         dat_d[l] = dat_q[l];
         if (adv) begin
            vld_d[l] = vld_q[l-1];
            if (vld_q[l-1]) dat_d[l] = compress(dat_q[l-1], opnd_count(l));
         end
      end
   end

   // Tree registers, cleared on reset so in-flight operands are discarded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int l = 0; l < LEVELS; l++) dat_q[l] <= '0;
      end else begin
         vld_q <= vld_d;
         for (int l = 0; l < LEVELS; l++) dat_q[l] <= dat_d[l];
      end
   end

   // Last level always sees three operands, so its output is slot0=sum, slot1=carry.
   assign tree_valid = vld_q[LEVELS-1];
   assign tree_s     = dat_q[LEVELS-1][0];
   assign tree_c     = dat_q[LEVELS-1][1];

`ifdef CSA_FINAL_ADD_EN
   logic             fvld_d, fvld_q;
   logic [WIDTH-1:0] fc_d, fc_q, fs_d, fs_q, fsum_d, fsum_q;

   // Resolve stage: carry-propagate add, c/s delayed alongside it.
   always_comb begin
      fvld_d = fvld_q;
      fc_d   = fc_q;
      fs_d   = fs_q;
      fsum_d = fsum_q;
      if (adv) begin
         fvld_d = tree_valid;
         if (tree_valid) begin
            fc_d   = tree_c;
            fs_d   = tree_s;
            fsum_d = tree_c + tree_s;
         end
      end
   end

   // Resolve stage registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fvld_q <= 1'b0;
         fc_q   <= '0;
         fs_q   <= '0;
         fsum_q <= '0;
      end else begin
         fvld_q <= fvld_d;
         fc_q   <= fc_d;
         fs_q   <= fs_d;
         fsum_q <= fsum_d;
      end
   end

   assign out_valid = fvld_q;
   assign out_c     = fc_q;
   assign out_s     = fs_q;
   assign out_sum   = fsum_q;
`else
   assign out_valid = tree_valid;
   assign out_c     = tree_c;
   assign out_s     = tree_s;
`endif

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Bench for csa_tree_pipe: 6x19 main instance plus 16x64 and 3x19 instances.
// Honours CSA_FINAL_ADD_EN (extra latency cycle, out_sum checks).
module tb_csa_tree_pipe;

`ifdef CSA_FINAL_ADD_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif
   localparam int LAT      = 3 + EXTRA;
   localparam int LAT_BIG  = 6 + EXTRA;
   localparam int LAT_TINY = 1 + EXTRA;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // main 6x19 instance
   logic                 in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
   logic [5:0][18:0]     in_data = '0;
   logic [18:0]          out_c, out_s;
   // 16x64 instance
   logic                 b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
   logic [15:0][63:0]    b_in_data = '0;
   logic [63:0]          b_out_c, b_out_s;
   // 3x19 instance
   logic                 t_in_valid = 1'b0, t_in_ready, t_out_valid, t_out_ready = 1'b1;
   logic [2:0][18:0]     t_in_data = '0;
   logic [18:0]          t_out_c, t_out_s;
`ifdef CSA_FINAL_ADD_EN
   logic [18:0] out_sum, t_out_sum;
   logic [63:0] b_out_sum;
`endif

   csa_tree_pipe #(.WIDTH(19), .NUM_IN(6)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_c(out_c), .out_s(out_s)
`ifdef CSA_FINAL_ADD_EN
      , .out_sum(out_sum)
`endif
   );

   csa_tree_pipe #(.WIDTH(64), .NUM_IN(16)) u_big (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_c(b_out_c), .out_s(b_out_s)
`ifdef CSA_FINAL_ADD_EN
      , .out_sum(b_out_sum)
`endif
   );

   csa_tree_pipe #(.WIDTH(19), .NUM_IN(3)) u_tiny (
      .clk(clk), .rst_n(rst_n), .in_valid(t_in_valid), .in_ready(t_in_ready),
      .in_data(t_in_data), .out_valid(t_out_valid), .out_ready(t_out_ready),
      .out_c(t_out_c), .out_s(t_out_s)
`ifdef CSA_FINAL_ADD_EN
      , .out_sum(t_out_sum)
`endif
   );

   int n_chk = 0;
   int n_pass = 0;
   int n_push = 0;
   int n_pop = 0;
   int cyc = 0;
   logic [18:0] exp_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [18:0] ref_sum(input logic [5:0][18:0] v);
      logic [18:0] s;
      s = '0;
      for (int j = 0; j < 6; j++) s = s + v[j];
      return s;
   endfunction

   // Scoreboard and protocol monitor on the main instance.
   logic        prev_hold = 1'b0;
   logic [18:0] prev_c, prev_s;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_hold = 1'b0;
      end else begin
         chk("in_ready_rule", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
         if (prev_hold) begin
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_c", {45'd0, out_c}, {45'd0, prev_c});
            chk("hold_s", {45'd0, out_s}, {45'd0, prev_s});
         end
         prev_hold = out_valid && !out_ready;
         prev_c    = out_c;
         prev_s    = out_s;
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_sum(in_data));
            n_push++;
         end
         if (out_valid && out_ready) begin
            n_pop++;
            if (exp_q.size() == 0) begin
               chk("unexpected_output", {63'd0, out_valid}, 64'd0);
            end else begin
               logic [18:0] e;
               e = exp_q.pop_front();
               chk("sb_sum", {45'd0, 19'(out_c + out_s)}, {45'd0, e});
               chk("sb_c0", {63'd0, out_c[0]}, 64'd0);
`ifdef CSA_FINAL_ADD_EN
               chk("sb_out_sum", {45'd0, out_sum}, {45'd0, e});
`endif
            end
         end
      end
   end

   // Presents one vector (called at posedge+1), returns at posedge+1 after accept.
   task automatic send(input logic [5:0][18:0] v);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      in_data  = v;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!ok) chk("send_timeout", 64'd0, 64'd1);
   endtask

   function automatic logic [5:0][18:0] rand_vec();
      logic [5:0][18:0] v;
      for (int j = 0; j < 6; j++) v[j] = 19'($urandom);
      return v;
   endfunction

   typedef struct {
      logic [5:0][18:0] data;
      logic [18:0]      exp;
   } vec_rec_t;

   vec_rec_t tbl [7];

   initial begin
      int seen;
      logic [18:0] got_sum, got_c;
      logic [63:0] b_sum;
      int t0;
      bit stale;

      tbl[0].data = {19'd6, 19'd5, 19'd4, 19'd3, 19'd2, 19'd1};                        tbl[0].exp = 19'h00015;
      tbl[1].data = {6{19'h7FFFF}};                                                     tbl[1].exp = 19'h7FFFA;
      tbl[2].data = '0;                                                                 tbl[2].exp = 19'h00000;
      tbl[3].data = {19'd0, 19'd0, 19'd0, 19'd0, 19'h40000, 19'h40000};                 tbl[3].exp = 19'h00000;
      tbl[4].data = {19'd0, 19'd0, 19'd0, 19'd0, 19'h00001, 19'h12345};                 tbl[4].exp = 19'h12346;
      tbl[5].data = {19'h60, 19'h50, 19'h40, 19'h30, 19'h20, 19'h10};                   tbl[5].exp = 19'h00150;
      tbl[6].data = {19'h00001, 19'd0, 19'd0, 19'd0, 19'd0, 19'h7FFFF};                 tbl[6].exp = 19'h00000;

      // reset state
      #3;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_c", {45'd0, out_c}, 64'd0);
      chk("rst_out_s", {45'd0, out_s}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
`ifdef CSA_FINAL_ADD_EN
      chk("rst_out_sum", {45'd0, out_sum}, 64'd0);
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // table vectors: exact latency and hand-computed sums
      foreach (tbl[i]) begin
         send(tbl[i].data);
         seen = 0;
         got_sum = '0;
         got_c = '0;
         for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk);
            if (out_valid && seen == 0) begin
               seen = k;
               got_sum = out_c + out_s;
               got_c = out_c;
`ifdef CSA_FINAL_ADD_EN
               chk("tbl_out_sum", {45'd0, out_sum}, {45'd0, tbl[i].exp});
`endif
            end
            @(posedge clk); #1;
         end
         chk("tbl_latency", 64'(seen), 64'(LAT));
         chk("tbl_sum", {45'd0, got_sum}, {45'd0, tbl[i].exp});
         chk("tbl_c0", {63'd0, got_c[0]}, 64'd0);
      end

      // back-to-back stream of 100 random vectors
      t0 = cyc;
      for (int i = 0; i < 100; i++) send(rand_vec());
      chk("stream_cycles", 64'(cyc - t0), 64'd100);
      repeat (LAT + 3) @(posedge clk);
      #1;
      chk("stream_drained", 64'(exp_q.size()), 64'd0);
      chk("stream_count", 64'(n_pop), 64'(n_push));

      // backpressure: out_ready low for 10 cycles while streaming
      fork
         begin
            for (int i = 0; i < 8; i++) send(rand_vec());
         end
         begin
            out_ready = 1'b0;
            repeat (8) @(posedge clk);
            @(negedge clk);
            chk("bp_full_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_full_in_ready", {63'd0, in_ready}, 64'd0);
            repeat (2) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      repeat (LAT + 3) @(posedge clk);
      #1;
      chk("bp_drained", 64'(exp_q.size()), 64'd0);
      chk("bp_count", 64'(n_pop), 64'(n_push));

      // reset with three vectors in flight
      for (int i = 0; i < 3; i++) send(rand_vec());
      chk("pre_reset_valid", {63'd0, out_valid}, 64'd1);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
      chk("mid_rst_c", {45'd0, out_c}, 64'd0);
      chk("mid_rst_s", {45'd0, out_s}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      stale = 1'b0;
      for (int k = 0; k < LAT + 3; k++) begin
         @(negedge clk);
         if (out_valid) stale = 1'b1;
      end
      chk("no_stale_after_rst", {63'd0, stale}, 64'd0);
      @(posedge clk); #1;

      // 16x64: operands 0..15
      for (int j = 0; j < 16; j++) b_in_data[j] = 64'(j);
      b_in_valid = 1'b1;
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      seen = 0;
      b_sum = '0;
      for (int k = 1; k <= LAT_BIG + 2; k++) begin
         @(negedge clk);
         if (b_out_valid && seen == 0) begin
            seen = k;
            b_sum = b_out_c + b_out_s;
`ifdef CSA_FINAL_ADD_EN
            chk("big_out_sum", b_out_sum, 64'h78);
`endif
         end
         @(posedge clk); #1;
      end
      chk("big_latency", 64'(seen), 64'(LAT_BIG));
      chk("big_sum", b_sum, 64'h78);

      // 3x19: single level, all-ones wrap
      t_in_data = {3{19'h7FFFF}};
      t_in_valid = 1'b1;
      @(posedge clk); #1;
      t_in_valid = 1'b0;
      seen = 0;
      got_sum = '0;
      for (int k = 1; k <= LAT_TINY + 2; k++) begin
         @(negedge clk);
         if (t_out_valid && seen == 0) begin
            seen = k;
            got_sum = t_out_c + t_out_s;
`ifdef CSA_FINAL_ADD_EN
            chk("tiny_out_sum", {45'd0, t_out_sum}, 64'h7FFFD);
`endif
         end
         @(posedge clk); #1;
      end
      chk("tiny_latency", 64'(seen), 64'(LAT_TINY));
      chk("tiny_sum", {45'd0, got_sum}, 64'h7FFFD);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
